count_sequencer: RTL and testbench

Initiator for the counter start/done/enabled handshake. On a `go` request it issues a programmed number of single-cycle `start` pulses to a downstream counter, one per run. Each run ends when the counter reports completion, and the block checks that run's enabled-cycle count and final value. It sits between control logic and a counter instance and reports batch completion plus a sticky first-error code.

---
 rtl/count_seq_pkg.sv | 19 +
 rtl/seq_timeout.sv | 35 +++
 rtl/count_sequencer.sv | 169 ++++++++++++++++
 tb/tb_count_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - state encoding and error codes shared by count_sequencer and its bench
package count_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_END,
    GAP,
    FINISH
  } state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_COUNT   = 2'd1;
  localparam err_code_t ERR_VALUE   = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/seq_timeout.sv
// rtl/seq_timeout.sv - per-run watchdog; expired is high on the TIMEOUT_CYCLES-th enabled cycle since clear
module seq_timeout #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count_q, count_d;

  assign expired = enable && (count_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - issues batches of counter start pulses and checks each run; watchdog under COUNT_SEQUENCER_TIMEOUT_EN
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int                      COUNTER_SIZE     = 8,
  parameter logic [COUNTER_SIZE-1:0] STOP_VALUE       = 8'hFF,
  parameter int                      EXPECTED_ENABLED = 256,
  parameter int                      RUN_COUNT_WIDTH  = 8,
  parameter int                      TIMEOUT_CYCLES   = 1023
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       go,
  input  logic [RUN_COUNT_WIDTH-1:0] runs,
  input  logic                       done_in,
  input  logic                       enabled_in,
  input  logic [COUNTER_SIZE-1:0]    value_in,
  output logic                       start,
  output logic                       busy,
  output logic                       batch_done,
  output logic                       error,
  output logic [1:0]                 error_code,
  output logic [RUN_COUNT_WIDTH-1:0] run_index
);

  localparam int              EN_W   = $clog2(EXPECTED_ENABLED) + 1;
  localparam logic [EN_W-1:0] EN_MAX = '1;

  state_e                     state_q, state_d;
  logic [RUN_COUNT_WIDTH-1:0] runs_q, runs_d;
  logic [RUN_COUNT_WIDTH-1:0] run_index_q, run_index_d;
  logic [EN_W-1:0]            en_cnt_q, en_cnt_d;
  logic                       error_q, error_d;
  err_code_t                  error_code_q, error_code_d;
  logic                       start_q, busy_q, batch_done_q;

  logic                       run_end;
  logic                       record;
  err_code_t                  record_code;
  logic                       timer_expired;

`ifdef COUNT_SEQUENCER_TIMEOUT_EN
  logic timer_clear, timer_en;

  assign timer_clear = (state_q == ISSUE);
  assign timer_en    = (state_q == WAIT_END) || (state_q == GAP);

  seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  // done with enabled still high is the last counting cycle, not the end of the run
  assign run_end = done_in && !enabled_in;

  always_comb begin
    state_d      = state_q;
    runs_d       = runs_q;
    run_index_d  = run_index_q;
    en_cnt_d     = en_cnt_q;
    error_d      = error_q;
    error_code_d = error_code_q;
    record       = 1'b0;
    record_code  = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (go) begin
          runs_d       = runs;
          run_index_d  = '0;
          error_d      = 1'b0;
          error_code_d = ERR_NONE;
          state_d      = (runs != '0) ? ISSUE : FINISH;
        end
      end
      ISSUE: begin
        en_cnt_d = '0;
        state_d  = WAIT_END;
      end
      WAIT_END: begin
        if (run_end) begin
          state_d = GAP;
          if (en_cnt_q != EN_W'(EXPECTED_ENABLED)) begin
            record      = 1'b1;
            record_code = ERR_COUNT;
          end else if (value_in != STOP_VALUE) begin
            record      = 1'b1;
            record_code = ERR_VALUE;
          end
        end else begin
          if (enabled_in && (en_cnt_q != EN_MAX)) begin
            en_cnt_d = en_cnt_q + 1'b1;
          end
          if (timer_expired) begin
            record      = 1'b1;
            record_code = ERR_TIMEOUT;
            state_d     = FINISH;
          end
        end
      end
      GAP: begin
        if (!done_in) begin
          if (run_index_q == runs_q - 1'b1) begin
            state_d = FINISH;
          end else begin
            run_index_d = run_index_q + 1'b1;
            state_d     = ISSUE;
          end
        end else if (timer_expired) begin
          record      = 1'b1;
          record_code = ERR_TIMEOUT;
          state_d     = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // only the first error of a batch is kept
    if (record && !error_q) begin
      error_d      = 1'b1;
      error_code_d = record_code;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      runs_q       <= '0;
      run_index_q  <= '0;
      en_cnt_q     <= '0;
      error_q      <= 1'b0;
      error_code_q <= ERR_NONE;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      runs_q       <= runs_d;
      run_index_q  <= run_index_d;
      en_cnt_q     <= en_cnt_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
      start_q      <= (state_q == ISSUE);
      busy_q       <= (state_q == ISSUE) || (state_q == WAIT_END) || (state_q == GAP);
      batch_done_q <= (state_q == FINISH);
    end
  end

  assign start      = start_q;
  assign busy       = busy_q;
  assign batch_done = batch_done_q;
  assign error      = error_q;
  assign error_code = error_code_q;
  assign run_index  = run_index_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - randomized self-checking bench with a counter responder and run-level reference model
module tb_count_sequencer;

  localparam int TO     = 400;
  localparam int EXP_EN = 256;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic [7:0] runs = 8'd0;
  logic       done_in = 1'b0;
  logic       enabled_in = 1'b0;
  logic [7:0] value_in = 8'd0;
  logic       start, busy, batch_done, error;
  logic [1:0] error_code;
  logic [7:0] run_index;

  int vec = 0;
  int errs = 0;

  int         cfg_len   [16];
  logic [7:0] cfg_final [16];
  int         cfg_hold  [16];
  bit         hang = 1'b0;

  int cyc = 0;
  int start_cycles[$];
  int bd_cycles[$];
  bit bd_busy;

  int resp_run = 0;
  int rem = 0;
  int tail = 0;
  int ci = 0;
  int cur = 0;

  count_sequencer #(
    .COUNTER_SIZE    (8),
    .STOP_VALUE      (8'hFF),
    .EXPECTED_ENABLED(EXP_EN),
    .RUN_COUNT_WIDTH (8),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .runs      (runs),
    .done_in   (done_in),
    .enabled_in(enabled_in),
    .value_in  (value_in),
    .start     (start),
    .busy      (busy),
    .batch_done(batch_done),
    .error     (error),
    .error_code(error_code),
    .run_index (run_index)
  );

  always #5 clock = ~clock;

  // counter responder: a start seen at an edge opens a run of cfg_len enabled cycles from the next cycle
  always @(posedge clock) begin
    bit st, rs, gs;
    st = start;
    rs = reset;
    gs = go && !busy;
    #1;
    if (rs) begin
      rem = 0; tail = 0; resp_run = 0;
      enabled_in = 1'b0; done_in = 1'b0; value_in = 8'd0;
    end else begin
      if (gs) resp_run = 0;
      if (st && !hang) begin
        cur = resp_run; rem = cfg_len[cur]; ci = 0; resp_run++;
        if (rem == 0) tail = 1 + cfg_hold[cur];
      end
      if (rem > 0) begin
        enabled_in = 1'b1; value_in = 8'(ci); done_in = (rem == 1);
        ci++; rem--;
        if (rem == 0) tail = 1 + cfg_hold[cur];
      end else if (tail > 0) begin
        enabled_in = 1'b0; done_in = 1'b1; value_in = cfg_final[cur]; tail--;
      end else begin
        enabled_in = 1'b0; done_in = 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    cyc++;
    #2;
    if (start) start_cycles.push_back(cyc);
    if (batch_done) begin
      bd_cycles.push_back(cyc);
      bd_busy = busy;
    end
  end

  function automatic int model_code(int n);
    for (int r = 0; r < n; r++) begin
      if (cfg_len[r] != EXP_EN) return 1;
      if (cfg_final[r] != 8'hFF) return 2;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_cfg(int n, int len, logic [7:0] fin);
    for (int r = 0; r < n; r++) begin
      cfg_len[r] = len; cfg_final[r] = fin; cfg_hold[r] = 0;
    end
  endtask

  task automatic launch(int n, output int go_c, output int s0, output int b0);
    s0 = start_cycles.size();
    b0 = bd_cycles.size();
    go = 1'b1; runs = 8'(n); go_c = cyc;
    tick();
    go = 1'b0; runs = 8'($urandom);
  endtask

  task automatic wait_bd(int b0, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bd_cycles.size() > b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0; hang = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vec++; if (start !== 1'b0) begin errs++; $display("FAIL reset_start: got %b want 0", start); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (batch_done !== 1'b0) begin errs++; $display("FAIL reset_batch_done: got %b want 0", batch_done); end
    vec++; if (error !== 1'b0) begin errs++; $display("FAIL reset_error: got %b want 0", error); end
    vec++; if (error_code !== 2'd0) begin errs++; $display("FAIL reset_error_code: got %0d want 0", error_code); end
    vec++; if (run_index !== 8'd0) begin errs++; $display("FAIL reset_run_index: got %0d want 0", run_index); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int gc, s0, b0;
    bit ok;
    fill_cfg(3, 256, 8'hFF);
    launch(3, gc, s0, b0);
    tick();
    vec++; if (start !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL nom_first_start: got start=%b busy=%b want 1 1", start, busy); end
    wait_bd(b0, 1200, ok);
    vec++; if (!ok) begin errs++; $display("FAIL nom_batch_done: got none want pulse"); end
    vec++; if (start_cycles.size() - s0 != 3) begin errs++; $display("FAIL nom_start_count: got %0d want 3", start_cycles.size() - s0); end
    vec++; if (start_cycles[s0] != gc + 2) begin errs++; $display("FAIL nom_start_latency: got %0d want %0d", start_cycles[s0] - gc, 2); end
    for (int r = 1; r < 3; r++) begin
      vec++;
      if (start_cycles[s0+r] - start_cycles[s0+r-1] != 260) begin
        errs++; $display("FAIL nom_spacing%0d: got %0d want 260", r, start_cycles[s0+r] - start_cycles[s0+r-1]);
      end
    end
    vec++; if (bd_busy !== 1'b0) begin errs++; $display("FAIL nom_busy_at_done: got %b want 0", bd_busy); end
    vec++; if (run_index !== 8'd2) begin errs++; $display("FAIL nom_run_index: got %0d want 2", run_index); end
    vec++; if (error !== 1'b0 || error_code !== 2'd0) begin errs++; $display("FAIL nom_error: got %b/%0d want 0/0", error, error_code); end
  endtask

  task automatic test_zero_runs();
    int gc, s0, b0;
    bit ok;
    launch(0, gc, s0, b0);
    wait_bd(b0, 20, ok);
    vec++; if (!ok) begin errs++; $display("FAIL zero_batch_done: got none want pulse"); end
    vec++; if (bd_cycles[b0] != gc + 2) begin errs++; $display("FAIL zero_done_latency: got %0d want 2", bd_cycles[b0] - gc); end
    vec++; if (start_cycles.size() != s0) begin errs++; $display("FAIL zero_starts: got %0d want 0", start_cycles.size() - s0); end
    vec++; if (error !== 1'b0 || bd_busy !== 1'b0) begin errs++; $display("FAIL zero_flags: got error=%b busy=%b want 0 0", error, bd_busy); end
  endtask

  task automatic test_count_error();
    int gc, s0, b0;
    bit ok;
    fill_cfg(2, 16, 8'h0F);
    launch(2, gc, s0, b0);
    wait_bd(b0, 200, ok);
    vec++; if (!ok) begin errs++; $display("FAIL cnt_batch_done: got none want pulse"); end
    vec++; if (start_cycles.size() - s0 != 2) begin errs++; $display("FAIL cnt_start_count: got %0d want 2", start_cycles.size() - s0); end
    vec++; if (error !== 1'b1 || error_code !== 2'd1) begin errs++; $display("FAIL cnt_code: got %b/%0d want 1/1", error, error_code); end
  endtask

  task automatic test_value_error();
    int gc, s0, b0;
    bit ok;
    fill_cfg(1, 256, 8'hFE);
    launch(1, gc, s0, b0);
    wait_bd(b0, 400, ok);
    vec++; if (!ok) begin errs++; $display("FAIL val_batch_done: got none want pulse"); end
    vec++; if (error !== 1'b1 || error_code !== 2'd2) begin errs++; $display("FAIL val_code: got %b/%0d want 1/2", error, error_code); end
  endtask

  task automatic test_random();
    int gc, s0, b0, n, exp_code, sp, last;
    bit ok;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 4);
      for (int r = 0; r < n; r++) begin
        case ($urandom_range(0, 5))
          0, 1, 2: cfg_len[r] = 256;
          3:       cfg_len[r] = 255;
          4:       cfg_len[r] = 257;
          default: cfg_len[r] = $urandom_range(1, 300);
        endcase
        case ($urandom_range(0, 3))
          0, 1:    cfg_final[r] = 8'hFF;
          2:       cfg_final[r] = 8'hFE;
          default: cfg_final[r] = 8'($urandom);
        endcase
        cfg_hold[r] = $urandom_range(0, 4);
      end
      exp_code = model_code(n);
      launch(n, gc, s0, b0);
      wait_bd(b0, n * 320 + 20, ok);
      vec++; if (!ok) begin errs++; $display("FAIL rnd%0d_batch_done: got none want pulse", it); end
      vec++; if (start_cycles.size() - s0 != n) begin errs++; $display("FAIL rnd%0d_starts: got %0d want %0d", it, start_cycles.size() - s0, n); end
      for (int r = 1; r < n; r++) begin
        sp = cfg_len[r-1] + cfg_hold[r-1] + 4;
        vec++;
        if (start_cycles[s0+r] - start_cycles[s0+r-1] != sp) begin
          errs++; $display("FAIL rnd%0d_spacing%0d: got %0d want %0d", it, r, start_cycles[s0+r] - start_cycles[s0+r-1], sp);
        end
      end
      last = start_cycles[s0+n-1] + cfg_len[n-1] + cfg_hold[n-1] + 4;
      vec++; if (bd_cycles[b0] != last) begin errs++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", it, bd_cycles[b0], last); end
      vec++; if (error_code !== 2'(exp_code) || error !== (exp_code != 0)) begin
        errs++; $display("FAIL rnd%0d_code: got %b/%0d want %b/%0d", it, error, error_code, exp_code != 0, exp_code);
      end
      vec++; if (run_index !== 8'(n - 1)) begin errs++; $display("FAIL rnd%0d_run_index: got %0d want %0d", it, run_index, n - 1); end
    end
  endtask

  task automatic test_timeout();
    int gc, s0, b0;
    bit ok;
    hang = 1'b1;
    fill_cfg(3, 256, 8'hFF);
    launch(3, gc, s0, b0);
`ifdef COUNT_SEQUENCER_TIMEOUT_EN
    wait_bd(b0, TO + 40, ok);
    vec++; if (!ok) begin errs++; $display("FAIL to_batch_done: got none want pulse"); end
    vec++; if (bd_cycles[b0] != start_cycles[s0] + TO + 1) begin
      errs++; $display("FAIL to_done_cycle: got %0d want %0d", bd_cycles[b0] - start_cycles[s0], TO + 1);
    end
    vec++; if (error !== 1'b1 || error_code !== 2'd3) begin errs++; $display("FAIL to_code: got %b/%0d want 1/3", error, error_code); end
    vec++; if (start_cycles.size() - s0 != 1) begin errs++; $display("FAIL to_abort: got %0d starts want 1", start_cycles.size() - s0); end
`else
    begin
      int low = 0;
      tick();
      for (int i = 0; i < 2000; i++) begin
        if (busy !== 1'b1) low++;
        tick();
      end
      vec++; if (low != 0) begin errs++; $display("FAIL noto_busy: got %0d idle cycles want 0", low); end
      vec++; if (error !== 1'b0 || error_code === 2'd3) begin errs++; $display("FAIL noto_code: got %b/%0d want 0/0", error, error_code); end
      vec++; if (bd_cycles.size() != b0) begin errs++; $display("FAIL noto_done: got %0d pulses want 0", bd_cycles.size() - b0); end
    end
`endif
    do_reset();
  endtask

  task automatic test_reset_midrun();
    int gc, s0, b0, k, sa;
    fill_cfg(3, 256, 8'hFF);
    launch(3, gc, s0, b0);
    k = 0;
    while (run_index !== 8'd1 && k < 800) begin
      tick();
      k++;
    end
    vec++; if (k >= 800) begin errs++; $display("FAIL mid_reach_run1: got run_index %0d want 1", run_index); end
    repeat (40) tick();
    go = 1'b1; runs = 8'd5;
    tick();
    go = 1'b0;
    repeat (10) tick();
    sa = start_cycles.size();
    reset = 1'b1;
    tick();
    vec++; if (start !== 1'b0 || busy !== 1'b0 || batch_done !== 1'b0) begin
      errs++; $display("FAIL mid_rst_ctrl: got start=%b busy=%b done=%b want 0 0 0", start, busy, batch_done);
    end
    vec++; if (error !== 1'b0 || error_code !== 2'd0 || run_index !== 8'd0) begin
      errs++; $display("FAIL mid_rst_status: got %b/%0d/%0d want 0/0/0", error, error_code, run_index);
    end
    vec++; if (sa - s0 != 2) begin errs++; $display("FAIL mid_starts_before: got %0d want 2", sa - s0); end
    tick();
    reset = 1'b0;
    repeat (300) tick();
    vec++; if (start_cycles.size() != sa || busy !== 1'b0) begin
      errs++; $display("FAIL mid_after_reset: got %0d starts busy=%b want 0 0", start_cycles.size() - sa, busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_runs();
    test_count_error();
    test_value_error();
    test_random();
    test_timeout();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
